// File: rtl/tmds_period_sequencer_if.sv
// tmds_period_sequencer_if: pixel/timing inputs and encoder/guard-band outputs of tmds_period_sequencer
interface tmds_period_sequencer_if;
  logic       de_in, hsync_in, vsync_in;
  logic [7:0] data_in_0, data_in_1, data_in_2;
  logic       enc_de;
  logic [7:0] enc_data_0, enc_data_1, enc_data_2;
  logic [1:0] enc_ctrl_0, enc_ctrl_1, enc_ctrl_2;
  logic       gb_active;
  logic [9:0] gb_code_0, gb_code_1, gb_code_2;
  logic       short_blank;
  modport master (
    output de_in, hsync_in, vsync_in, data_in_0, data_in_1, data_in_2,
    input  enc_de, enc_data_0, enc_data_1, enc_data_2, enc_ctrl_0, enc_ctrl_1, enc_ctrl_2,
    input  gb_active, gb_code_0, gb_code_1, gb_code_2, short_blank
  );
  modport slave (
    input  de_in, hsync_in, vsync_in, data_in_0, data_in_1, data_in_2,
    output enc_de, enc_data_0, enc_data_1, enc_data_2, enc_ctrl_0, enc_ctrl_1, enc_ctrl_2,
    output gb_active, gb_code_0, gb_code_1, gb_code_2, short_blank
  );
endinterface

// File: rtl/tmds_period_sequencer.sv
// tmds_period_sequencer: delays the pixel/timing stream and inserts the HDMI video preamble and guard band.
// Define TMDS_SEQ_HDMI_EN for HDMI framing; left undefined the block is a plain DVI delay line.
module tmds_period_sequencer #(
  parameter int PRE_LEN = 8,
  parameter int GB_LEN  = 2
) (
  input logic                    clk_pix,
  input logic                    rst_pix_n,
  tmds_period_sequencer_if.slave bus
);
  localparam int D = PRE_LEN + GB_LEN;
  localparam int W = 27;
  logic [W-1:0] r_sr [D];
  logic [W-1:0] w_in, w_tail;
  logic         r_de;
  logic [1:0]   r_c0;
  logic [7:0]   r_d0, r_d1, r_d2;
  // stage layout: {de, vsync, hsync, red, green, blue}
  assign w_in   = {bus.de_in, bus.vsync_in, bus.hsync_in, bus.data_in_2, bus.data_in_1, bus.data_in_0};
  assign w_tail = r_sr[D-1];
  always_ff @(posedge clk_pix or negedge rst_pix_n)
    if (!rst_pix_n) begin
      for (int i = 0; i < D; i++) r_sr[i] <= '0;
      r_de <= 1'b0;
      r_c0 <= '0;
      r_d0 <= '0;
      r_d1 <= '0;
      r_d2 <= '0;
    end else begin
      r_sr[0] <= w_in;
      for (int i = 1; i < D; i++) r_sr[i] <= r_sr[i-1];
      r_de <= w_tail[W-1];
      r_c0 <= w_tail[25:24];
      r_d2 <= w_tail[W-1] ? w_tail[23:16] : '0;
      r_d1 <= w_tail[W-1] ? w_tail[15:8]  : '0;
      r_d0 <= w_tail[W-1] ? w_tail[7:0]   : '0;
    end
  assign bus.enc_de     = r_de;
  assign bus.enc_data_0 = r_d0;
  assign bus.enc_data_1 = r_d1;
  assign bus.enc_data_2 = r_d2;
  assign bus.enc_ctrl_0 = r_c0;
  assign bus.enc_ctrl_2 = 2'b00;
  assign bus.gb_code_0  = 10'b1011001100;
  assign bus.gb_code_1  = 10'b0100110011;
  assign bus.gb_code_2  = 10'b1011001100;
`ifdef TMDS_SEQ_HDMI_EN
  localparam int M  = PRE_LEN > GB_LEN ? PRE_LEN : GB_LEN;
  localparam int CW = M > 1 ? $clog2(M) : 1;
  typedef enum logic [1:0] {CTRL, PREAMBLE, GUARD, VIDEO} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_c1, r_gb, r_sb;
  logic          w_any_de, w_rise;
  // a rise is only framed when the whole lookahead window is blank
  always_comb begin
    w_any_de = 1'b0;
    for (int i = 0; i < D; i++) w_any_de = w_any_de | r_sr[i][W-1];
  end
  assign w_rise = bus.de_in & ~r_sr[0][W-1];
  always_ff @(posedge clk_pix or negedge rst_pix_n)
    if (!rst_pix_n) begin
      r_state <= CTRL;
      r_cnt   <= '0;
      r_c1    <= 1'b0;
      r_gb    <= 1'b0;
      r_sb    <= 1'b0;
    end else begin
      r_sb <= r_sb | (w_rise & w_any_de);
      if (w_rise && !w_any_de) begin
        r_state <= PREAMBLE;
        r_cnt   <= '0;
        r_c1    <= 1'b1;
        r_gb    <= 1'b0;
      end else
        case (r_state)
          CTRL:     if (w_tail[W-1]) r_state <= VIDEO;
          PREAMBLE: if (r_cnt == CW'(PRE_LEN - 1)) begin
                      r_state <= GUARD;
                      r_cnt   <= '0;
                      r_c1    <= 1'b0;
                      r_gb    <= 1'b1;
                    end else r_cnt <= r_cnt + 1'b1;
          GUARD:    if (r_cnt == CW'(GB_LEN - 1)) begin
                      r_state <= VIDEO;
                      r_gb    <= 1'b0;
                    end else r_cnt <= r_cnt + 1'b1;
          default:  if (!w_tail[W-1]) r_state <= CTRL;
        endcase
    end
  assign bus.enc_ctrl_1  = {1'b0, r_c1};
  assign bus.gb_active   = r_gb;
  assign bus.short_blank = r_sb;
`else
  assign bus.enc_ctrl_1  = 2'b00;
  assign bus.gb_active   = 1'b0;
  assign bus.short_blank = 1'b0;
`endif
endmodule
